// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the imem boot loader
package imem_boot_loader_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_HDR_HI  = 3'd0,
        ST_HDR_LO  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_RUN     = 3'd4,
        ST_ERROR   = 3'd5
    } boot_state_e;

    // States in which the loader is still consuming the byte stream
    function automatic logic is_loading(input boot_state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_PAYLOAD) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream input and imem write port bundle
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Loader side: consumes bytes, drives the imem write port
    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    // Host/memory side: produces bytes, observes the imem write port
    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_asm.sv
// rtl/imem_boot_loader_asm.sv - big-endian byte-to-word assembler with running XOR
module boot_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic [BYTE_W-1:0]  in_byte,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word,
    output logic [BYTE_W-1:0]  xor_acc
);

    // Only the three earlier bytes need storing; the fourth arrives on in_byte
    logic [23:0]       shreg_q, shreg_d;
    logic [1:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] xor_q, xor_d;

    // Shift in accepted bytes MSB first, count position in word, fold into checksum
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        xor_d   = xor_q;
        if (clear) begin
            shreg_d = '0;
            idx_d   = '0;
            xor_d   = '0;
        end else if (accept) begin
            shreg_d = {shreg_q[15:0], in_byte};
            idx_d   = idx_q + 2'd1;
            xor_d   = xor_q ^ in_byte;
        end
    end

    // Assembler state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            idx_q   <= '0;
            xor_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
        end
    end

    assign word_valid = accept & (idx_q == 2'd3);
    assign word       = {shreg_q, in_byte};
    assign xor_acc    = xor_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a checksummed program image into imem and releases core reset
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_boot_loader_if.slave    bus,
    input  logic                 reload,
    output logic                 core_reset,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    boot_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic               in_ready_q, in_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
    logic               core_reset_q, core_reset_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               xfer;
    logic [CNT_W-1:0]   hdr_n;
    logic               asm_clear;
    logic               asm_accept;
    logic               word_valid;
    logic [INSTR_W-1:0] word;
    logic [BYTE_W-1:0]  xor_acc;

    assign xfer       = bus.in_valid & in_ready_q;
    assign hdr_n      = {cnt_q[15:8], bus.in_data};
    assign asm_clear  = xfer & (state_q == ST_HDR_LO);
    assign asm_accept = xfer & (state_q == ST_PAYLOAD);

    boot_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .accept     (asm_accept),
        .in_byte    (bus.in_data),
        .word_valid (word_valid),
        .word       (word),
        .xor_acc    (xor_acc)
    );

    // Frame parser: next state, write-port and status outputs derived from next state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        unique case (state_q)
            ST_HDR_HI: begin
                if (xfer) begin
                    cnt_d   = {bus.in_data, cnt_q[7:0]};
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    cnt_d = hdr_n;
                    ptr_d = '0;
                    if (32'(hdr_n) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (hdr_n == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr_q[ADDR_W-1:0];
                    imem_wdata_d = word;
                    ptr_d        = ptr_q + 16'd1;
                    // ptr_d equal to N means this was word N-1; the wrapped address is never written
                    if (ptr_d == cnt_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (bus.in_data == xor_acc) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_HDR_HI;
                end
            end
            default: state_d = ST_HDR_HI;
        endcase
        in_ready_d   = is_loading(state_d);
        core_reset_d = (state_d != ST_RUN);
        done_d       = (state_d == ST_RUN);
        error_d      = (state_d == ST_ERROR);
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HDR_HI;
            cnt_q        <= '0;
            ptr_q        <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_reset     = core_reset_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule
